wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin arbiter that multiplexes NUM_REQ requesters
// onto one Wishbone bus master through a start/active handshake.
//
// Ports
//   wb_clk, wb_rst_n      : clock, synchronous active-low reset
//   req                   : per-requester transfer request (level)
//   req_address           : packed addresses, requester i at [i*aw +: aw]
//   req_selection         : packed byte selects, requester i at [i*4 +: 4]
//   req_write             : per-requester write flag
//   req_data_wr           : packed write data, requester i at [i*dw +: dw]
//   grant                 : one-hot owner of the bus master
//   done                  : one-cycle completion pulse to the owner
//   timeout               : one-cycle timeout pulse to the owner
//   req_data_rd           : read data of the last completed read
//   busy                  : high whenever a transfer is in flight
//   start                 : one-cycle launch pulse to the bus master
//   address / selection / write / data_wr : latched transfer fields
//   active                : bus master busy flag
//   data_rd               : bus master read data

module wb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int aw      = 32,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,

    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*aw-1:0]  req_address,
    input  logic [NUM_REQ*4-1:0]   req_selection,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*dw-1:0]  req_data_wr,

    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     timeout,
    output logic [dw-1:0]          req_data_rd,
    output logic                   busy,

    output logic                   start,
    output logic [aw-1:0]          address,
    output logic [3:0]             selection,
    output logic                   write,
    output logic [dw-1:0]          data_wr,
    input  logic                   active,
    input  logic [dw-1:0]          data_rd
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      CNT_MAX  = CW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACTIVE,
        WAIT_DONE,
        COMPLETE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        win_q,   win_d;
    logic [IW-1:0]        last_q,  last_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [aw-1:0]        addr_q,  addr_d;
    logic [3:0]           sel_q,   sel_d;
    logic                 we_q,    we_d;
    logic [dw-1:0]        wdat_q,  wdat_d;
    logic [dw-1:0]        rdat_q,  rdat_d;

    // Unpacked views of the per-requester fields
    logic [aw-1:0] addr_arr [NUM_REQ];
    logic [3:0]    sel_arr  [NUM_REQ];
    logic [dw-1:0] wdat_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_address[g*aw +: aw];
        assign sel_arr[g]  = req_selection[g*4 +: 4];
        assign wdat_arr[g] = req_data_wr[g*dw +: dw];
    end

    // Round-robin pick: scan last+1, last+2, ... wrapping at NUM_REQ.
    // The first hit in scan order wins, so the previous owner is last.
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] req_rot;
    int                 cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        req_rot    = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            req_rot = req >> cand;
            if (!pick_valid && req_rot[0]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    logic cnt_hit;
    assign cnt_hit = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        start   = 1'b0;
        done    = '0;
        timeout = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid && !active) begin
                    grant_d = ONE << pick_idx;
                    win_d   = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    sel_d   = sel_arr[pick_idx];
                    we_d    = req_write[pick_idx];
                    wdat_d  = wdat_arr[pick_idx];
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_ACTIVE;
            end

            WAIT_ACTIVE: begin
                if (cnt_hit) begin
                    timeout = grant_q;
                    grant_d = '0;
                    last_d  = win_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (active) begin
                        state_d = WAIT_DONE;
                    end
                end
            end

            WAIT_DONE: begin
                // A timeout wins over a same-cycle completion so that the
                // counter bound is strict.
                if (cnt_hit) begin
                    timeout = grant_q;
                    grant_d = '0;
                    last_d  = win_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!active) begin
                        if (!we_q) begin
                            rdat_d = data_rd;
                        end
                        state_d = COMPLETE;
                    end
                end
            end

            COMPLETE: begin
                done    = grant_q;
                grant_d = '0;
                last_d  = win_q;
                state_d = IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign address     = addr_q;
    assign selection   = sel_q;
    assign write       = we_q;
    assign data_wr     = wdat_q;
    assign req_data_rd = rdat_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: randomized self-checking bench for wb_master_arbiter
// against a transaction-level round-robin reference model.

module tb_wb_master_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*32-1:0] req_address;
    logic [N*4-1:0] req_selection;
    logic [N-1:0]   req_write;
    logic [N*32-1:0] req_data_wr;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   timeout;
    logic [31:0]    req_data_rd;
    logic           busy;
    logic           start;
    logic [31:0]    address;
    logic [3:0]     selection;
    logic           write;
    logic [31:0]    data_wr;
    logic           active;
    logic [31:0]    data_rd;

    logic [31:0] addr_a [N];
    logic [3:0]  sel_a  [N];
    logic        wr_a   [N];
    logic [31:0] wd_a   [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_address[g*32 +: 32] = addr_a[g];
        assign req_selection[g*4 +: 4] = sel_a[g];
        assign req_write[g]            = wr_a[g];
        assign req_data_wr[g*32 +: 32] = wd_a[g];
    end

    wb_master_arbiter #(
        .NUM_REQ(N), .aw(32), .dw(32), .TIMEOUT(TO)
    ) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .req(req), .req_address(req_address),
        .req_selection(req_selection), .req_write(req_write),
        .req_data_wr(req_data_wr),
        .grant(grant), .done(done), .timeout(timeout),
        .req_data_rd(req_data_rd), .busy(busy),
        .start(start), .address(address), .selection(selection),
        .write(write), .data_wr(data_wr),
        .active(active), .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model state
    int          last_m;
    logic [31:0] rd_m;

    function automatic int rr_pick(input logic [N-1:0] r);
        int w;
        bit found;
        w = -1;
        found = 0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_m + k) % N;
            if (!found && r[i]) begin
                w = i;
                found = 1;
            end
        end
        return w;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            addr_a[i] = $urandom;
            sel_a[i]  = 4'($urandom_range(0, 15));
            wr_a[i]   = 1'($urandom_range(0, 1));
            wd_a[i]   = $urandom;
        end
    endtask

    // Caller sits at a negedge where the previous transfer has ended.
    task automatic do_xfer(input logic [N-1:0] reqv, input int w,
                           input int a, input bit to, input bit to_wa,
                           input logic [31:0] rdv, input bit perturb,
                           output int win);
        logic [N-1:0] oh;
        logic [31:0]  ea, ed;
        logic [3:0]   es;
        logic         ew;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
        chk("idle_done", done, 0);
        win = rr_pick(reqv);
        oh  = N'(1) << win;
        ea  = addr_a[win];
        es  = sel_a[win];
        ew  = wr_a[win];
        ed  = wd_a[win];
        req = reqv;
        @(negedge clk);
        chk("start", start, 1);
        chk("grant", grant, oh);
        chk("address", address, ea);
        chk("selection", selection, es);
        chk("write", write, ew);
        chk("data_wr", data_wr, ed);
        chk("busy", busy, 1);
        if (perturb) begin
            addr_a[win] = ~ea;
            req[win] = 1'b0;
        end
        if (to) begin
            if (!to_wa) active = 1'b1;
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                chk("to_wait_tmo", timeout, 0);
                chk("to_wait_done", done, 0);
            end
            @(negedge clk);
            chk("to_pulse", timeout, oh);
            chk("to_nodone", done, 0);
            chk("to_rd", req_data_rd, rd_m);
            active = 1'b0;
            last_m = win;
        end else begin
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                chk("wa_start", start, 0);
                chk("wa_done", done, 0);
            end
            active = 1'b1;
            for (int j = 0; j < a; j++) begin
                @(negedge clk);
                chk("wd_done", done, 0);
                chk("wd_tmo", timeout, 0);
                chk("wd_grant", grant, oh);
            end
            active  = 1'b0;
            data_rd = rdv;
            @(negedge clk);
            if (!ew) rd_m = rdv;
            chk("done", done, oh);
            chk("done_tmo", timeout, 0);
            chk("done_grant", grant, oh);
            chk("hold_addr", address, ea);
            chk("rd_data", req_data_rd, rd_m);
            last_m = win;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot",
                {61'b0, $onehot0(grant), $onehot0(done), $onehot0(timeout)},
                64'h7);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int win;
        rst_n   = 1'b0;
        req     = '0;
        active  = 1'b0;
        data_rd = '0;
        rand_fields();
        last_m  = N - 1;
        rd_m    = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address, 0);
        chk("rst_sel", selection, 0);
        chk("rst_write", write, 0);
        chk("rst_wdata", data_wr, 0);
        chk("rst_rdata", req_data_rd, 0);
        rst_n = 1'b1;

        // active high in IDLE holds off arbitration
        req = 4'b0001;
        active = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("blk_busy", busy, 0);
        chk("blk_grant", grant, 0);
        req = '0;
        active = 1'b0;

        // single read
        addr_a[0] = 32'h100;
        wr_a[0] = 1'b0;
        do_xfer(4'b0001, 1, 2, 0, 0, 32'hDEADBEEF, 0, win);
        chk("read_win", win, 0);
        chk("read_data", req_data_rd, 32'hDEADBEEF);

        // write leaves read data alone
        rand_fields();
        wr_a[2]  = 1'b1;
        wd_a[2]  = 32'hA5A5A5A5;
        sel_a[2] = 4'hF;
        do_xfer(4'b0100, 0, 2, 0, 0, 32'h12345678, 0, win);
        chk("write_win", win, 2);
        chk("write_rd", req_data_rd, 32'hDEADBEEF);

        // fields and req changed after grant
        rand_fields();
        do_xfer(4'b0010, 2, 3, 0, 0, $urandom, 1, win);
        chk("pert_win", win, 1);

        // timeouts with active stuck high and never rising
        rand_fields();
        do_xfer(4'b1000, 0, 0, 1, 0, 0, 0, win);
        chk("to_win", win, 3);
        rand_fields();
        do_xfer(4'b0110, 0, 0, 1, 1, 0, 0, win);
        chk("to_wa_win", win, 1);

        // reset in WAIT_DONE
        rand_fields();
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("mr_start", start, 1);
        active = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_busy", busy, 1);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("mr_grant", grant, 0);
        chk("mr_done", done, 0);
        chk("mr_tmo", timeout, 0);
        chk("mr_start0", start, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_addr", address, 0);
        chk("mr_rd", req_data_rd, 0);
        last_m = N - 1;
        rd_m   = '0;
        active = 1'b0;
        rst_n  = 1'b1;

        // contention with all requests held: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            do_xfer(4'b1111, $urandom_range(0, 2), $urandom_range(2, 4),
                    0, 0, $urandom, 0, win);
            chk("rr_order", win, i % N);
        end

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] rv;
            rv = N'($urandom_range(1, 15));
            rand_fields();
            do_xfer(rv, $urandom_range(0, 2), $urandom_range(2, 4),
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 1)), win);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
